// File: rtl/cc_deserializer_if.sv
// Miss-request, memory read-beat and return-FIFO signals of the miss-fill assembler.
interface cc_deserializer_if;
    logic         miss_req_valid_i;
    logic         miss_req_ready_o;
    logic [5:0]   miss_req_offset_i;
    logic [63:0]  mem_rdata_i;
    logic         mem_rvalid_i;
    logic         mem_rlast_i;
    logic         mem_rready_o;
    logic         fifo_full_i;
    logic         fifo_wren_o;
    logic [517:0] fifo_wdata_o;
    logic         err_o;

    modport slave (
        input  miss_req_valid_i, miss_req_offset_i, mem_rdata_i, mem_rvalid_i,
               mem_rlast_i, fifo_full_i,
        output miss_req_ready_o, mem_rready_o, fifo_wren_o, fifo_wdata_o, err_o
    );

    modport master (
        output miss_req_valid_i, miss_req_offset_i, mem_rdata_i, mem_rvalid_i,
               mem_rlast_i, fifo_full_i,
        input  miss_req_ready_o, mem_rready_o, fifo_wren_o, fifo_wdata_o, err_o
    );
endinterface

// File: rtl/cc_deserializer.sv
// Miss-fill assembler: 8 x 64-bit beats -> one {offset, line} return-FIFO entry.
// Optional rlast protocol check enabled by defining CC_DESERIALIZER_LAST_CHECK_EN.
module cc_deserializer (
    input  logic             clk,
    input  logic             rst,
    cc_deserializer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [5:0]       offset_q, offset_d;
    logic [7:0][63:0] line_q, line_d;
    logic             req_hs, beat_hs;

    assign bus.miss_req_ready_o = (state_q == IDLE);
    assign bus.mem_rready_o     = (state_q == COLLECT);
    assign bus.fifo_wren_o      = (state_q == PUSH) && !bus.fifo_full_i;
    assign bus.fifo_wdata_o     = {offset_q, line_q};

    assign req_hs  = bus.miss_req_valid_i && (state_q == IDLE);
    assign beat_hs = bus.mem_rvalid_i && (state_q == COLLECT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        line_d   = line_q;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    offset_d = bus.miss_req_offset_i;
                    cnt_d    = 3'd0;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (beat_hs) begin
                    // Word 0 lands in the top slot, so slot index is 7-cnt.
                    line_d[~cnt_q] = bus.mem_rdata_i;
                    cnt_d          = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = PUSH;
                end
            end
            PUSH: begin
                if (!bus.fifo_full_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            offset_q <= 6'd0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
            line_q   <= line_d;
        end
    end

`ifdef CC_DESERIALIZER_LAST_CHECK_EN
    logic err_q, err_d;

    // Sticky: rlast must coincide exactly with the eighth accepted beat.
    always_comb begin
        err_d = err_q;
        if (beat_hs && (bus.mem_rlast_i != (cnt_q == 3'd7))) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_cc_deserializer.sv
// Directed self-checking bench for cc_deserializer (works with or without the rlast-check macro).
module tb_cc_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    cc_deserializer_if bus();

    cc_deserializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.miss_req_valid_i  = 1'b0;
        bus.miss_req_offset_i = 6'd0;
        bus.mem_rdata_i       = 64'd0;
        bus.mem_rvalid_i      = 1'b0;
        bus.mem_rlast_i       = 1'b0;
        bus.fifo_full_i       = 1'b0;
    endtask

    task automatic send_req(input logic [5:0] off);
        bus.miss_req_valid_i  = 1'b1;
        bus.miss_req_offset_i = off;
        next_cycle();
        bus.miss_req_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        n_checks++;
        if (bus.miss_req_ready_o !== 1'b1 || bus.mem_rready_o !== 1'b0 || bus.fifo_wren_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: ready=%b rready=%b wren=%b, want 1 0 0",
                     bus.miss_req_ready_o, bus.mem_rready_o, bus.fifo_wren_o);
        end
        n_checks++;
        if (bus.fifo_wdata_o !== 518'd0 || bus.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: wdata=%h err=%b, want 0 0", bus.fifo_wdata_o, bus.err_o);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic();
        logic [511:0] exp;
        exp = '0;
        // A beat offered in IDLE must not be taken
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hDEAD;
        #1;
        n_checks++;
        if (bus.mem_rready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_rready: got %b want 0", bus.mem_rready_o);
        end
        bus.mem_rvalid_i = 1'b0;
        send_req(6'h18);
        for (int k = 0; k < 8; k++) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 64'(k);
            bus.mem_rlast_i  = (k == 7);
            exp[511-64*k -: 64] = 64'(k);
            #1;
            n_checks++;
            if (bus.mem_rready_o !== 1'b1 || bus.fifo_wren_o !== 1'b0 || bus.miss_req_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_collect beat %0d: rready=%b wren=%b ready=%b, want 1 0 0",
                         k, bus.mem_rready_o, bus.fifo_wren_o, bus.miss_req_ready_o);
            end
            next_cycle();
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
        #1;
        n_checks++;
        if (bus.fifo_wren_o !== 1'b1 || bus.mem_rready_o !== 1'b0 || bus.miss_req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_push: wren=%b rready=%b ready=%b, want 1 0 0",
                     bus.fifo_wren_o, bus.mem_rready_o, bus.miss_req_ready_o);
        end
        n_checks++;
        if (bus.fifo_wdata_o !== {6'h18, exp}) begin
            n_fail++;
            $display("FAIL basic_wdata: got %h want %h", bus.fifo_wdata_o, {6'h18, exp});
        end
        n_checks++;
        if (bus.fifo_wdata_o[511:448] !== 64'h0 || bus.fifo_wdata_o[63:0] !== 64'h7) begin
            n_fail++;
            $display("FAIL basic_slots: word0=%h word7=%h want 0 7",
                     bus.fifo_wdata_o[511:448], bus.fifo_wdata_o[63:0]);
        end
        next_cycle();
        n_checks++;
        if (bus.miss_req_ready_o !== 1'b1 || bus.fifo_wren_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_back_idle: ready=%b wren=%b want 1 0",
                     bus.miss_req_ready_o, bus.fifo_wren_o);
        end
    endtask

    task automatic test_gaps();
        logic [511:0] exp;
        int acc;
        int cyc;
        exp = '0;
        acc = 0;
        cyc = 0;
        for (int k = 0; k < 8; k++) exp[511-64*k -: 64] = 64'hA000_0000_0000_0000 + 64'(k);
        send_req(6'h2A);
        while (acc < 8 && cyc < 64) begin
            bus.mem_rvalid_i = cyc[0];
            bus.mem_rdata_i  = 64'hA000_0000_0000_0000 + 64'(acc);
            bus.mem_rlast_i  = (acc == 7);
            #1;
            n_checks++;
            if (bus.fifo_wren_o !== 1'b0) begin
                n_fail++;
                $display("FAIL gaps_early_write cycle %0d: wren=%b want 0", cyc, bus.fifo_wren_o);
            end
            if (bus.mem_rvalid_i && bus.mem_rready_o) acc++;
            next_cycle();
            cyc++;
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
        n_checks++;
        if (acc != 8) begin
            n_fail++;
            $display("FAIL gaps_timeout: accepted %0d beats want 8", acc);
        end
        #1;
        n_checks++;
        if (bus.fifo_wren_o !== 1'b1 || bus.fifo_wdata_o !== {6'h2A, exp}) begin
            n_fail++;
            $display("FAIL gaps_push: wren=%b wdata=%h want 1 %h", bus.fifo_wren_o, bus.fifo_wdata_o, {6'h2A, exp});
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [511:0] exp;
        exp = '0;
        send_req(6'h05);
        for (int k = 0; k < 8; k++) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = {32'hC0DE_0000 + 32'(k), 32'h1234_5678};
            bus.mem_rlast_i  = (k == 7);
            exp[511-64*k -: 64] = {32'hC0DE_0000 + 32'(k), 32'h1234_5678};
            next_cycle();
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
        bus.fifo_full_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (bus.fifo_wren_o !== 1'b0 || bus.miss_req_ready_o !== 1'b0 || bus.fifo_wdata_o !== {6'h05, exp}) begin
                n_fail++;
                $display("FAIL bp_stall cycle %0d: wren=%b ready=%b wdata=%h", i,
                         bus.fifo_wren_o, bus.miss_req_ready_o, bus.fifo_wdata_o);
            end
            next_cycle();
        end
        bus.fifo_full_i = 1'b0;
        #1;
        n_checks++;
        if (bus.fifo_wren_o !== 1'b1 || bus.miss_req_ready_o !== 1'b0 || bus.fifo_wdata_o !== {6'h05, exp}) begin
            n_fail++;
            $display("FAIL bp_release: wren=%b ready=%b wdata=%h want 1 0 %h",
                     bus.fifo_wren_o, bus.miss_req_ready_o, bus.fifo_wdata_o, {6'h05, exp});
        end
        next_cycle();
        n_checks++;
        if (bus.miss_req_ready_o !== 1'b1 || bus.fifo_wren_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_after: ready=%b wren=%b want 1 0", bus.miss_req_ready_o, bus.fifo_wren_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [511:0] exp;
        exp = '0;
        send_req(6'h3F);
        for (int k = 0; k < 4; k++) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 64'hFFFF_0000_0000_0000 | 64'(k);
            next_cycle();
        end
        bus.mem_rvalid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.miss_req_ready_o !== 1'b1 || bus.mem_rready_o !== 1'b0 ||
            bus.fifo_wren_o !== 1'b0 || bus.fifo_wdata_o !== 518'd0) begin
            n_fail++;
            $display("FAIL rst_mid: ready=%b rready=%b wren=%b wdata=%h want 1 0 0 0",
                     bus.miss_req_ready_o, bus.mem_rready_o, bus.fifo_wren_o, bus.fifo_wdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        send_req(6'h00);
        for (int k = 0; k < 8; k++) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 64'h0101_0101_0101_0101 * 64'(k + 1);
            bus.mem_rlast_i  = (k == 7);
            exp[511-64*k -: 64] = 64'h0101_0101_0101_0101 * 64'(k + 1);
            next_cycle();
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
        #1;
        n_checks++;
        if (bus.fifo_wren_o !== 1'b1 || bus.fifo_wdata_o !== {6'h00, exp}) begin
            n_fail++;
            $display("FAIL rst_refill: wren=%b wdata=%h want 1 %h", bus.fifo_wren_o, bus.fifo_wdata_o, {6'h00, exp});
        end
        next_cycle();
    endtask

    task automatic test_rlast();
        logic [511:0] exp;
        logic         exp_err;
`ifdef CC_DESERIALIZER_LAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        exp = '0;
        send_req(6'h08);
        for (int k = 0; k < 8; k++) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = 64'h5A5A_0000_0000_0000 + 64'(k);
            bus.mem_rlast_i  = (k == 3) || (k == 7);
            exp[511-64*k -: 64] = 64'h5A5A_0000_0000_0000 + 64'(k);
            #1;
            n_checks++;
            if (bus.err_o !== ((k > 3) ? exp_err : 1'b0)) begin
                n_fail++;
                $display("FAIL rlast_err beat %0d: err=%b want %b", k, bus.err_o, (k > 3) ? exp_err : 1'b0);
            end
            next_cycle();
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
        #1;
        n_checks++;
        if (bus.fifo_wren_o !== 1'b1 || bus.fifo_wdata_o !== {6'h08, exp} || bus.err_o !== exp_err) begin
            n_fail++;
            $display("FAIL rlast_push: wren=%b err=%b wdata=%h want 1 %b %h",
                     bus.fifo_wren_o, bus.err_o, bus.fifo_wdata_o, exp_err, {6'h08, exp});
        end
        next_cycle();
        next_cycle();
        n_checks++;
        if (bus.err_o !== exp_err) begin
            n_fail++;
            $display("FAIL rlast_sticky: err=%b want %b", bus.err_o, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_reset_mid();
        test_rlast();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cc_deserializer.md
# cc_deserializer

Miss-fill assembler for the cache controller's read-return path. It accepts one miss request carrying the critical byte offset, collects eight 64-bit beats from the memory read channel into a 512-bit line, and pushes one 518-bit entry {offset, line} into the return-data FIFO. The serializer stage drains that FIFO toward the CPU in critical-word-first order. Exactly one miss is in flight at a time.

## Interface
- Parameters: none. Widths are fixed: 64-bit beat, 8 beats per line, 6-bit offset, 518-bit FIFO entry.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- miss_req_valid_i  input  1  miss request present.
- miss_req_ready_o  output  1  request accepted when valid and ready are both high.
- miss_req_offset_i  input  6  byte offset of the critical word within the 64 B line.
- mem_rdata_i  input  64  memory read beat.
- mem_rvalid_i  input  1  beat valid.
- mem_rlast_i  input  1  final beat of the burst.
- mem_rready_o  output  1  beat accepted when valid and ready are both high.
- fifo_full_i  input  1  return FIFO cannot take a write this cycle.
- fifo_wren_o  output  1  single-cycle write strobe.
- fifo_wdata_o  output  518  [517:512] offset, [511:0] line.
- err_o  output  1  sticky protocol error (see Configuration).

## Operation
- FSM states: IDLE, COLLECT, PUSH.
- IDLE
  - miss_req_ready_o = 1; all other strobes 0.
  - On a request handshake: latch miss_req_offset_i, clear beat counter cnt[2:0], go to COLLECT.
- COLLECT
  - mem_rready_o = 1.
  - Each beat handshake writes mem_rdata_i into slot cnt; slot k occupies line bits [511-64k : 448-64k]. Word 0 is at the MSBs.
  - cnt increments on each beat.
  - Beats arrive in linear order, word 0 first. Critical-word reordering is the consumer's job.
  - When the beat with cnt==7 is accepted, go to PUSH.
  - Cycles with mem_rvalid_i low hold all state.
- PUSH
  - mem_rready_o = 0 and miss_req_ready_o = 0.
  - fifo_wren_o = !fifo_full_i. This is combinational from state and fifo_full_i.
  - On the write cycle, go to IDLE.
  - While fifo_full_i is high, stay in PUSH with fifo_wdata_o held stable.
- fifo_wdata_o is driven continuously from the offset and line registers. It is only meaningful while fifo_wren_o is high.
- The offset is stored unchanged. The consumer uses offset[5:3] as the critical word index.

## Timing
- Reset values: state = IDLE, cnt = 0, offset = 0, line = 0, err_o = 0.
- Output values in reset:
  - miss_req_ready_o = 1.
  - mem_rready_o = 0, fifo_wren_o = 0.
  - fifo_wdata_o = 0.
- Best case: request handshake in cycle 0, beats in cycles 1–8, FIFO write in cycle 9, next request accepted in cycle 10.
- Back-pressure: each cycle with fifo_full_i high adds one cycle in PUSH. There is no upper bound.
- A beat presented while in IDLE or PUSH is not accepted, because mem_rready_o = 0.
- Reset asserted mid-COLLECT or mid-PUSH:
  - Immediately returns the FSM to IDLE.
  - The partial line is discarded and no FIFO write occurs.
  - The line register clears to 0.
- cnt is 3 bits and wraps only by leaving COLLECT. It is never reused without a clear in IDLE.

## Configuration
- Macro: CC_DESERIALIZER_LAST_CHECK_EN.
- When defined:
  - err_o is set and held until reset if mem_rlast_i differs from (cnt==7) on any accepted beat.
  - A beat with mem_rlast_i high before cnt==7 sets err_o.
  - The line still completes only after 8 beats.
  - No FIFO write is suppressed.
- When undefined: mem_rlast_i is ignored and err_o is tied to 0.

## Test plan
- Offset 6'h18, beats 64'h0..64'h7 back-to-back, FIFO not full -> fifo_wren_o pulses once in cycle 9; wdata[517:512]=6'h18, [511:448]=64'h0, [63:0]=64'h7.
- Beats with mem_rvalid_i toggling every other cycle -> the same line is assembled; the write occurs one cycle after the 8th accepted beat.
- fifo_full_i high for 5 cycles on entering PUSH -> fifo_wren_o stays 0 for 5 cycles, then pulses once with unchanged wdata; miss_req_ready_o stays 0 until the cycle after the write.
- Async rst pulse after 4 beats -> immediate IDLE, no write; a new request with offset 6'h00 and a full 8-beat burst then produces a correct line.
- Macro defined, mem_rlast_i high on beat 3 -> err_o = 1 from the next cycle and stays 1; the line is still pushed after beat 8.
- Macro undefined, same stimulus -> err_o stays 0 and the line is pushed normally.
